lsu_arbiter: RTL and testbench
==============================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority to requester 0.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports r0_valid_i and r1_valid_i, input, 1 bit each: request pending (0 = core, 1 = debug/DMA).
REQ-005 SHALL have ports r0_addr_i and r1_addr_i, input, 16 bits each: load/store address.
REQ-006 SHALL have ports r0_wdata_i and r1_wdata_i, input, 32 bits each: store data.
REQ-007 SHALL have ports r0_wren_i and r1_wren_i, input, 1 bit each: 1 = store, 0 = load.
REQ-008 SHALL have ports r0_funct3_i and r1_funct3_i, input, 3 bits each: access size/sign.
REQ-009 SHALL have ports r0_ready_o and r1_ready_o, output, 1 bit each: request accepted this cycle.
REQ-010 SHALL have ports r0_rvalid_o and r1_rvalid_o, output, 1 bit each: response/ack pulse.
REQ-011 SHALL have port rdata_o, output, 32 bits: load result, shared by both requesters.
REQ-012 SHALL have port lsu_addr_o, output, 16 bits: to LSU address.
REQ-013 SHALL have port lsu_st_data_o, output, 32 bits: to LSU store data.
REQ-014 SHALL have port lsu_wren_o, output, 1 bit: to LSU write enable.
REQ-015 SHALL have port lsu_funct3_o, output, 3 bits: to LSU funct3.
REQ-016 SHALL have port lsu_ld_data_i, input, 32 bits: LSU load data (registered in LSU, valid one cycle after issue).
REQ-017 SHALL have port busy_o, output, 1 bit: transaction in flight.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-019 IDLE: if any valid, SHALL assert exactly one ready combinationally to the winner, capture its addr/wdata/wren/funct3 into a command register, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-020 ready SHALL only be asserted in IDLE; a requester SHALL be allowed to drop valid before ready with no side effect.
REQ-021 ISSUE: SHALL drive lsu_* from the command register with lsu_wren_o = captured wren for exactly one cycle, then go to RESP.
REQ-022 RESP: SHALL assert lsu_addr_o/lsu_funct3_o unchanged and lsu_wren_o = 0, and for a load SHALL register lsu_ld_data_i into rdata_o.
REQ-023 RESP: SHALL pulse the winner's rvalid for one cycle, then return to IDLE.
REQ-024 rvalid SHALL be asserted in the cycle after RESP, together with valid rdata_o; for a store, rdata_o SHALL be 0.
REQ-025 rdata_o SHALL hold its value until the next response.
REQ-026 Request-to-rvalid latency SHALL be 3 cycles; throughput SHALL be 1 transaction per 3 cycles; a new grant in IDLE MAY coincide with the previous rvalid pulse.
REQ-027 Outside ISSUE, lsu_wren_o SHALL be 0; in IDLE, lsu_addr_o/lsu_st_data_o/lsu_funct3_o SHALL hold the last command.
REQ-028 ARB_MODE=0: with both valid, SHALL grant the requester not granted last; last-grant pointer SHALL update on each accept.
REQ-029 ARB_MODE=1: with both valid, SHALL always grant requester 0.
REQ-030 A single valid requester SHALL be granted regardless of the pointer.
REQ-031 busy_o SHALL be 1 in ISSUE and RESP, and 0 in IDLE.
REQ-032 Inputs SHALL be ignored outside IDLE; the command register SHALL not change mid-transaction.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE; all ready/rvalid, lsu_wren_o and busy_o = 0; lsu_addr_o/lsu_st_data_o/rdata_o = 0; lsu_funct3_o = 0; last-grant pointer = requester 1 (so requester 0 wins first tie).
REQ-034 Reset during ISSUE or RESP SHALL abort the transaction, produce no rvalid, and be followed by no further LSU write.
REQ-035 Release of rst_n SHALL take effect at the next clk edge; the first grant SHALL be possible in the first cycle after release.

Verification
REQ-036 Scenario: r0 store addr 0x7004, wdata 0xDEADBEEF, funct3 2 -> r0_ready in cycle 0, lsu_wren_o=1 only in cycle 1, r0_rvalid in cycle 3, rdata_o=0.
REQ-037 Scenario: r1 load addr 0x7004, LSU returns 0xDEADBEEF -> r1_ready in cycle 0, lsu_wren_o=0 throughout, r1_rvalid in cycle 3, rdata_o=0xDEADBEEF.
REQ-038 Scenario: ARB_MODE=0, both valid continuously for 4 transactions -> grants r0, r1, r0, r1, with ready pulses every 3 cycles.
REQ-039 Scenario: ARB_MODE=1, both valid for 3 transactions -> all grants to r0; r1 granted only after r0 drops valid.
REQ-040 Scenario: rst_n asserted in the ISSUE cycle of a store -> lsu_wren_o drops immediately, no rvalid, busy_o=0, and the next tie goes to r0.
REQ-041 Scenario: r1_valid pulsed high for one cycle during RESP of r0 and then dropped -> no r1_ready and no r1 transaction issued.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Purpose : two-requester front end that shares one LSU port between the core (r0) and debug/DMA (r1).
// Latency : grant in cycle 0 (combinational ready), LSU issue in cycle 1, rvalid + rdata in cycle 3.
// Backpr. : ready is only offered in IDLE, so at most one transaction is in flight; a requester simply
//           holds valid until it sees ready, and may withdraw valid beforehand without side effects.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_valid_i                 request pending from requester N (0 = core, 1 = debug/DMA)
//   rN_addr_i / rN_wdata_i     16-bit address, 32-bit store data
//   rN_wren_i / rN_funct3_i    1 = store / 0 = load, access size and sign
//   rN_ready_o                 request accepted this cycle
//   rN_rvalid_o                one-cycle response pulse, rdata_o valid alongside it
//   rdata_o                    load result shared by both requesters, 0 for a store
//   lsu_addr_o .. lsu_funct3_o command towards the LSU (held between transactions)
//   lsu_ld_data_i              LSU load data, valid one cycle after issue
//   busy_o                     transaction in flight
module lsu_arbiter #(
    parameter int ARB_MODE = 0   // 0 = round-robin, 1 = fixed priority to requester 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid_i,
    input  logic [15:0] r0_addr_i,
    input  logic [31:0] r0_wdata_i,
    input  logic        r0_wren_i,
    input  logic [2:0]  r0_funct3_i,
    output logic        r0_ready_o,
    output logic        r0_rvalid_o,

    input  logic        r1_valid_i,
    input  logic [15:0] r1_addr_i,
    input  logic [31:0] r1_wdata_i,
    input  logic        r1_wren_i,
    input  logic [2:0]  r1_funct3_i,
    output logic        r1_ready_o,
    output logic        r1_rvalid_o,

    output logic [31:0] rdata_o,

    output logic [15:0] lsu_addr_o,
    output logic [31:0] lsu_st_data_o,
    output logic        lsu_wren_o,
    output logic [2:0]  lsu_funct3_o,
    input  logic [31:0] lsu_ld_data_i,

    output logic        busy_o
);

    localparam bit FIXED_PRIO = (ARB_MODE == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [2:0]  funct3;
    } cmd_t;

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        last_q, last_d;      // requester granted most recently (0 or 1)
    logic        win_q, win_d;        // owner of the transaction in flight
    logic [1:0]  rvalid_q, rvalid_d;  // bit N = response pulse for requester N
    logic [31:0] rdata_q, rdata_d;

    logic        gnt0, gnt1;
    cmd_t        req0, req1;

    assign req0 = '{addr: r0_addr_i, wdata: r0_wdata_i, wren: r0_wren_i, funct3: r0_funct3_i};
    assign req1 = '{addr: r1_addr_i, wdata: r1_wdata_i, wren: r1_wren_i, funct3: r1_funct3_i};

    // Arbitration. Gated with rst_n so no ready escapes while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (r0_valid_i && r1_valid_i) begin
                // Tie: fixed priority always picks r0; round-robin picks the
                // requester that did not win last time.
                if (FIXED_PRIO || last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = r0_valid_i;
                gnt1 = r1_valid_i;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        last_d   = last_q;
        win_d    = win_q;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    cmd_d   = gnt1 ? req1 : req0;
                    win_d   = gnt1;
                    last_d  = gnt1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                // LSU load data is valid now (one cycle after issue); stores
                // return zero so a stale load value never leaks to the owner.
                rvalid_d = {win_q, ~win_q};
                rdata_d  = cmd_q.wren ? 32'h0 : lsu_ld_data_i;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset lands last_q on requester 1 so r0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            rvalid_q <= 2'b00;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            last_q   <= last_d;
            win_q    <= win_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign r0_ready_o    = gnt0;
    assign r1_ready_o    = gnt1;
    assign r0_rvalid_o   = rvalid_q[0];
    assign r1_rvalid_o   = rvalid_q[1];
    assign rdata_o       = rdata_q;

    // The command register drives the LSU continuously so address/data/funct3
    // hold the last command between transactions; the write strobe is only
    // opened during ISSUE, and it drops the instant reset forces IDLE.
    assign lsu_addr_o    = cmd_q.addr;
    assign lsu_st_data_o = cmd_q.wdata;
    assign lsu_funct3_o  = cmd_q.funct3;
    assign lsu_wren_o    = (state_q == ISSUE) && cmd_q.wren;

    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
module tb_lsu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0_valid, r1_valid, r0_wren, r1_wren;
    logic [15:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata, lsu_ld_data;
    logic [2:0]  r0_f3, r1_f3;

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    logic [1:0]  r0_ready, r1_ready, r0_rvalid, r1_rvalid, lsu_wren, busy;
    logic [31:0] rdata [2];
    logic [31:0] st_data [2];
    logic [15:0] addr_o [2];
    logic [2:0]  f3_o [2];

    lsu_arbiter #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid_i(r0_valid), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r0_wren_i(r0_wren), .r0_funct3_i(r0_f3),
        .r0_ready_o(r0_ready[0]), .r0_rvalid_o(r0_rvalid[0]),
        .r1_valid_i(r1_valid), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_wren_i(r1_wren), .r1_funct3_i(r1_f3),
        .r1_ready_o(r1_ready[0]), .r1_rvalid_o(r1_rvalid[0]),
        .rdata_o(rdata[0]),
        .lsu_addr_o(addr_o[0]), .lsu_st_data_o(st_data[0]),
        .lsu_wren_o(lsu_wren[0]), .lsu_funct3_o(f3_o[0]),
        .lsu_ld_data_i(lsu_ld_data),
        .busy_o(busy[0])
    );

    lsu_arbiter #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid_i(r0_valid), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r0_wren_i(r0_wren), .r0_funct3_i(r0_f3),
        .r0_ready_o(r0_ready[1]), .r0_rvalid_o(r0_rvalid[1]),
        .r1_valid_i(r1_valid), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_wren_i(r1_wren), .r1_funct3_i(r1_f3),
        .r1_ready_o(r1_ready[1]), .r1_rvalid_o(r1_rvalid[1]),
        .rdata_o(rdata[1]),
        .lsu_addr_o(addr_o[1]), .lsu_st_data_o(st_data[1]),
        .lsu_wren_o(lsu_wren[1]), .lsu_funct3_o(f3_o[1]),
        .lsu_ld_data_i(lsu_ld_data),
        .busy_o(busy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is described by how many cycles have
    // passed since its grant (1 = sent to LSU, 2 = waiting for load data),
    // and the response is scheduled for the following cycle.
    bit          m_act   [2];
    int          m_age   [2];
    bit          m_win   [2];
    bit          m_last  [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    bit          m_wren  [2];
    logic [2:0]  m_f3    [2];
    logic [31:0] m_rdata [2];
    bit          m_rv0   [2];
    bit          m_rv1   [2];

    task automatic model_reset(input int m);
        m_act[m] = 0; m_age[m] = 0; m_win[m] = 0; m_last[m] = 1;
        m_addr[m] = '0; m_wdata[m] = '0; m_wren[m] = 0; m_f3[m] = '0;
        m_rdata[m] = '0; m_rv0[m] = 0; m_rv1[m] = 0;
    endtask

    // Called once per cycle at the falling edge: compare both instances
    // against the model, then advance the model by one clock.
    task automatic model_cmp();
        for (int m = 0; m < 2; m++) begin
            int    g;
            string p;
            p = $sformatf("m%0d", m);
            if (!rst_n) model_reset(m);
            g = -1;
            if (rst_n && !m_act[m]) begin
                if (r0_valid && r1_valid) g = (m == 1) ? 0 : (m_last[m] ? 0 : 1);
                else if (r0_valid) g = 0;
                else if (r1_valid) g = 1;
            end
            chk({p, " r0_ready"},  32'(r0_ready[m]),  32'(g == 0));
            chk({p, " r1_ready"},  32'(r1_ready[m]),  32'(g == 1));
            chk({p, " r0_rvalid"}, 32'(r0_rvalid[m]), 32'(m_rv0[m]));
            chk({p, " r1_rvalid"}, 32'(r1_rvalid[m]), 32'(m_rv1[m]));
            chk({p, " rdata"},     rdata[m],          m_rdata[m]);
            chk({p, " lsu_addr"},  32'(addr_o[m]),    32'(m_addr[m]));
            chk({p, " lsu_st"},    st_data[m],        m_wdata[m]);
            chk({p, " lsu_f3"},    32'(f3_o[m]),      32'(m_f3[m]));
            chk({p, " lsu_wren"},  32'(lsu_wren[m]),  32'(m_act[m] && m_age[m] == 1 && m_wren[m]));
            chk({p, " busy"},      32'(busy[m]),      32'(m_act[m]));
            if (rst_n) begin
                m_rv0[m] = 0;
                m_rv1[m] = 0;
                if (m_act[m]) begin
                    if (m_age[m] == 2) begin
                        m_rv0[m]   = !m_win[m];
                        m_rv1[m]   = m_win[m];
                        m_rdata[m] = m_wren[m] ? 32'h0 : lsu_ld_data;
                        m_act[m]   = 0;
                    end else begin
                        m_age[m]++;
                    end
                end else if (g >= 0) begin
                    m_act[m]  = 1;
                    m_age[m]  = 1;
                    m_win[m]  = (g == 1);
                    m_last[m] = (g == 1);
                    if (g == 0) begin
                        m_addr[m] = r0_addr; m_wdata[m] = r0_wdata; m_wren[m] = r0_wren; m_f3[m] = r0_f3;
                    end else begin
                        m_addr[m] = r1_addr; m_wdata[m] = r1_wdata; m_wren[m] = r1_wren; m_f3[m] = r1_f3;
                    end
                end
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req_clear();
        r0_valid = 0; r1_valid = 0; r0_wren = 0; r1_wren = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        r0_f3 = '0; r1_f3 = '0;
    endtask

    initial begin
        int rst_cnt;
        bit e0r0 [4];
        bit e1r0 [4];
        rst_n = 0;
        req_clear();
        lsu_ld_data = 32'h0;
        // Reset with both requesters asking: nothing may be granted.
        r0_valid = 1; r1_valid = 1;
        #1;
        mid();
        for (int m = 0; m < 2; m++) begin
            chk("reset r0_ready", 32'(r0_ready[m]), 32'd0);
            chk("reset r1_ready", 32'(r1_ready[m]), 32'd0);
            chk("reset busy",     32'(busy[m]),     32'd0);
            chk("reset lsu_addr", 32'(addr_o[m]),   32'd0);
            chk("reset rdata",    rdata[m],         32'd0);
        end
        nxt();
        mid(); nxt();

        // Store from r0 granted in the very cycle reset is released.
        rst_n = 1; req_clear();
        r0_valid = 1; r0_addr = 16'h7004; r0_wdata = 32'hDEADBEEF; r0_wren = 1; r0_f3 = 3'd2;
        mid(); chk("st c0 r0_ready", 32'(r0_ready[0]), 32'd1); chk("st c0 wren", 32'(lsu_wren[0]), 32'd0); nxt();
        r0_valid = 0;
        mid();
        chk("st c1 wren", 32'(lsu_wren[0]), 32'd1);
        chk("st c1 addr", 32'(addr_o[0]), 32'h7004);
        chk("st c1 data", st_data[0], 32'hDEADBEEF);
        chk("st c1 f3",   32'(f3_o[0]), 32'd2);
        nxt();
        mid(); chk("st c2 wren", 32'(lsu_wren[0]), 32'd0); chk("st c2 busy", 32'(busy[0]), 32'd1); nxt();
        mid(); chk("st c3 r0_rvalid", 32'(r0_rvalid[0]), 32'd1); chk("st c3 rdata", rdata[0], 32'd0);
        chk("st c3 busy", 32'(busy[0]), 32'd0); nxt();

        // Load from r1; LSU returns DEADBEEF.
        req_clear();
        r1_valid = 1; r1_addr = 16'h7004; r1_wren = 0; r1_f3 = 3'd2; lsu_ld_data = 32'hDEADBEEF;
        mid(); chk("ld c0 r1_ready", 32'(r1_ready[1]), 32'd1); nxt();
        r1_valid = 0;
        mid(); chk("ld c1 wren", 32'(lsu_wren[1]), 32'd0); nxt();
        mid(); chk("ld c2 wren", 32'(lsu_wren[1]), 32'd0); nxt();
        mid(); chk("ld c3 r1_rvalid", 32'(r1_rvalid[1]), 32'd1); chk("ld c3 r0_rvalid", 32'(r1_rvalid[1] & r0_rvalid[1]), 32'd0);
        chk("ld c3 rdata", rdata[1], 32'hDEADBEEF); nxt();

        // Both requesters continuously valid; r0 withdraws from cycle 9.
        e0r0 = '{1, 0, 1, 0};
        e1r0 = '{1, 1, 1, 0};
        req_clear();
        r0_addr = 16'h0100; r1_addr = 16'h0200;
        for (int c = 0; c < 12; c++) begin
            r0_valid = (c < 9); r1_valid = 1;
            mid();
            if (c % 3 == 0) begin
                chk($sformatf("rr grant%0d r0", c / 3), 32'(r0_ready[0]), 32'(e0r0[c / 3]));
                chk($sformatf("rr grant%0d r1", c / 3), 32'(r1_ready[0]), 32'(!e0r0[c / 3]));
                chk($sformatf("fp grant%0d r0", c / 3), 32'(r0_ready[1]), 32'(e1r0[c / 3]));
                chk($sformatf("fp grant%0d r1", c / 3), 32'(r1_ready[1]), 32'(!e1r0[c / 3]));
            end else begin
                chk("rr ready gap", 32'({r0_ready[0], r1_ready[0]}), 32'd0);
            end
            nxt();
        end

        // Reset during ISSUE of an r0 store aborts it and restores the pointer.
        req_clear();
        r0_valid = 1; r0_addr = 16'h1234; r0_wdata = 32'hCAFEF00D; r0_wren = 1; r0_f3 = 3'd2;
        mid(); chk("abort c0 r0_ready", 32'(r0_ready[0]), 32'd1); nxt();
        r0_valid = 0; rst_n = 0;
        mid(); chk("abort wren", 32'(lsu_wren[0]), 32'd0); chk("abort busy", 32'(busy[0]), 32'd0); nxt();
        rst_n = 1;
        mid(); chk("abort no rvalid a", 32'(r0_rvalid[0]), 32'd0); nxt();
        mid(); chk("abort no rvalid b", 32'(r0_rvalid[0]), 32'd0); chk("abort no wren", 32'(lsu_wren[0]), 32'd0); nxt();
        r0_valid = 1; r1_valid = 1;
        mid(); chk("post-reset tie r0", 32'(r0_ready[0]), 32'd1); chk("post-reset tie r1", 32'(r1_ready[0]), 32'd0); nxt();
        req_clear();
        for (int c = 0; c < 3; c++) begin mid(); nxt(); end

        // r1 pulses valid during RESP of an r0 load and then drops it.
        r0_valid = 1; r0_addr = 16'h0042; r0_wren = 0; r0_f3 = 3'd4; lsu_ld_data = 32'h55AA55AA;
        mid(); nxt();
        r0_valid = 0;
        mid(); nxt();
        r1_valid = 1; r1_addr = 16'h0099;
        mid(); chk("pulse r1_ready resp", 32'(r1_ready[0]), 32'd0); nxt();
        r1_valid = 0;
        mid(); chk("pulse r0_rvalid", 32'(r0_rvalid[0]), 32'd1); chk("pulse rdata", rdata[0], 32'h55AA55AA); nxt();
        for (int c = 0; c < 3; c++) begin
            mid(); chk("pulse no r1 txn", 32'({busy[0], r1_rvalid[0], r1_ready[0]}), 32'd0); nxt();
        end

        // Random traffic with occasional asynchronous resets.
        rst_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rst_cnt > 0) begin
                rst_n = 0; rst_cnt--;
            end else begin
                rst_n = 1;
                if ($urandom_range(0, 99) == 0) rst_cnt = $urandom_range(1, 3);
            end
            r0_valid = ($urandom_range(0, 9) < 6);
            r1_valid = ($urandom_range(0, 9) < 6);
            r0_addr = 16'($urandom); r1_addr = 16'($urandom);
            r0_wdata = $urandom; r1_wdata = $urandom;
            r0_wren = 1'($urandom); r1_wren = 1'($urandom);
            r0_f3 = 3'($urandom); r1_f3 = 3'($urandom);
            lsu_ld_data = $urandom;
            mid(); nxt();
        end
        rst_n = 1; req_clear();
        for (int c = 0; c < 4; c++) begin mid(); nxt(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
